// File: rtl/io_input_port.sv
// rtl/io_input_port.sv - synchronized, debounced switch-word input port with a ready flag polled by the CPU
// Optional feature macro: INPUT_OVERRUN_EN (sticky overrun flag reported on IData[1])
module io_input_port #(
    parameter int DATA_W          = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] switches,
    input  logic              enter_key,
    input  logic [1:0]        control,
    output logic [31:0]       IData,
    output logic              InputReady
);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DATA_W-1:0] sw_meta;
    logic [DATA_W-1:0] sw_sync;
    logic              key_meta;
    logic              key_sync;
    logic              key_deb;
    logic [CNT_W-1:0]  count;

    state_t            state;
    state_t            state_next;
    logic              capture;

    logic [DATA_W-1:0] data_reg;
    logic              ready;
    logic              overrun;

    logic              key_differs;
    logic              key_accept;
    logic              press_evt;
    logic              release_evt;
    logic              read_ack;

    assign key_differs = (key_sync != key_deb);
    assign key_accept  = key_differs && (count == CNT_LAST);
    assign press_evt   = key_accept && !key_sync;
    assign release_evt = key_accept && key_sync;
    assign read_ack    = (control == 2'd3);

    // Synchronizers and debounce; the key resets to the released (high) level.
    always_ff @(negedge clock) begin
        if (reset) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= 1'b1;
            key_sync <= 1'b1;
            key_deb  <= 1'b1;
            count    <= '0;
        end else begin
            sw_meta  <= switches;
            sw_sync  <= sw_meta;
            key_meta <= enter_key;
            key_sync <= key_meta;
            if (!key_differs) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                key_deb <= key_sync;
                count   <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (press_evt) begin
                    state_next = HELD;
                    capture    = 1'b1;
                end
            end
            HELD: begin
                if (release_evt) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A capture on the same edge as a read wins, so the fresh word is never lost.
    always_ff @(negedge clock) begin
        if (reset) begin
            data_reg <= '0;
            ready    <= 1'b0;
        end else if (capture) begin
            data_reg <= sw_sync;
            ready    <= 1'b1;
        end else if (read_ack) begin
            ready    <= 1'b0;
        end
    end

`ifdef INPUT_OVERRUN_EN
    always_ff @(negedge clock) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (capture && ready) begin
            overrun <= 1'b1;
        end else if (read_ack && !capture) begin
            overrun <= 1'b0;
        end
    end
`else
    assign overrun = 1'b0;
`endif

    always_comb begin
        IData = '0;
        if (read_ack) begin
            IData[DATA_W-1:0] = data_reg;
        end else begin
            IData[1:0] = {overrun, ready};
        end
    end

    assign InputReady = ready;

endmodule

// File: tb/tb_io_input_port.sv
// tb/tb_io_input_port.sv - randomized and directed bench for io_input_port against a behavioural model
module tb_io_input_port;

    localparam int N = 4;
`ifdef INPUT_OVERRUN_EN
    localparam bit OVR_ON = 1'b1;
`else
    localparam bit OVR_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] switches = '0;
    logic        enter_key = 1'b1;
    logic [1:0]  control = '0;
    logic [31:0] IData;
    logic        InputReady;

    int n_checks = 0;
    int n_fail   = 0;

    io_input_port #(
        .DATA_W         (16),
        .DEBOUNCE_CYCLES(N),
        .CNT_W          (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .switches  (switches),
        .enter_key (enter_key),
        .control   (control),
        .IData     (IData),
        .InputReady(InputReady)
    );

    always #5 clock = ~clock;

    // Reference model: raw inputs reach the logic two edges late; the debounced key
    // flips after N consecutive edges of disagreement; a flip to pressed captures.
    logic        key_q[$];
    logic [15:0] sw_q[$];
    logic        m_deb;
    int          m_run;
    logic [15:0] m_data;
    logic        m_rdy;
    logic        m_ovr;
    bit          m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_idata(input logic [1:0] c);
        if (c == 2'd3) return {16'h0, m_data};
        return {30'h0, m_ovr, m_rdy};
    endfunction

    task automatic model_step(input logic k, input logic [15:0] sw, input logic [1:0] c, input logic r);
        logic        s_key;
        logic [15:0] s_sw;
        bit          cap;
        if (r) begin
            key_q   = '{1'b1, 1'b1};
            sw_q    = '{16'h0, 16'h0};
            m_deb   = 1'b1;
            m_run   = 0;
            m_data  = '0;
            m_rdy   = 1'b0;
            m_ovr   = 1'b0;
            m_valid = 1'b1;
            return;
        end
        s_key = key_q[$];
        s_sw  = sw_q[$];
        void'(key_q.pop_back());
        void'(sw_q.pop_back());
        key_q.push_front(k);
        sw_q.push_front(sw);
        cap   = 1'b0;
        m_run = (s_key != m_deb) ? m_run + 1 : 0;
        if (m_run == N) begin
            m_deb = s_key;
            m_run = 0;
            cap   = !s_key;
        end
        if (cap) begin
            if (m_rdy && OVR_ON) m_ovr = 1'b1;
            m_data = s_sw;
            m_rdy  = 1'b1;
        end else if (c == 2'd3) begin
            m_rdy = 1'b0;
            m_ovr = 1'b0;
        end
    endtask

    task automatic cycle(input logic k, input logic [15:0] sw, input logic [1:0] c, input logic r);
        enter_key = k;
        switches  = sw;
        control   = c;
        reset     = r;
        #1;
        if (m_valid) begin
            check("pre_idata", IData, exp_idata(c));
            check("pre_ready", {31'h0, InputReady}, {31'h0, m_rdy});
        end
        @(negedge clock);
        model_step(k, sw, c, r);
        #1;
        check("post_idata", IData, exp_idata(c));
        check("post_ready", {31'h0, InputReady}, {31'h0, m_rdy});
    endtask

    task automatic do_reset();
        cycle(1'b1, 16'h0, 2'd0, 1'b1);
        cycle(1'b1, 16'h0, 2'd0, 1'b1);
        check("reset_idata", IData, 32'h0);
        check("reset_ready", {31'h0, InputReady}, 32'h0);
    endtask

    task automatic press(input logic [15:0] sw, input int hold);
        for (int i = 0; i < hold; i++) cycle(1'b0, sw, 2'd0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, sw, 2'd0, 1'b0);
    endtask

    initial begin
        logic        k;
        int          run_left;

        do_reset();

        // 1: latency of exactly 2 + N edges, then read and acknowledge
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 16'hA5C3, 2'd0, 1'b0);
            if (i == 5) check("t1_not_yet", {31'h0, InputReady}, 32'h0);
            if (i == 6) check("t1_ready", {31'h0, InputReady}, 32'h1);
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0, 2'd0, 1'b0);
        cycle(1'b1, 16'h0, 2'd3, 1'b0);
        check("t1_ack_ready", {31'h0, InputReady}, 32'h0);
        control = 2'd3;
        #1;
        check("t1_data", IData, 32'h0000A5C3);

        // 2: short glitch is ignored
        do_reset();
        cycle(1'b0, 16'h1234, 2'd0, 1'b0);
        cycle(1'b0, 16'h1234, 2'd0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 16'h1234, 2'd0, 1'b0);
        check("t2_status", IData, 32'h0);

        // 3: long hold captures once with the first word
        for (int i = 0; i < 100; i++) cycle(1'b0, (i < 10) ? 16'h0001 : 16'h0002, 2'd0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0002, 2'd0, 1'b0);
        cycle(1'b1, 16'h0002, 2'd3, 1'b0);
        check("t3_data", IData, 32'h00000001);

        // 4: two presses without a read keep the newest word
        press(16'h1111, 8);
        press(16'h2222, 8);
        check("t4_status", IData, OVR_ON ? 32'h3 : 32'h1);
        cycle(1'b1, 16'h0, 2'd3, 1'b0);
        check("t4_data", IData, 32'h00002222);
        cycle(1'b1, 16'h0, 2'd0, 1'b0);
        check("t4_cleared", IData, 32'h0);

        // 5: capture and read on the same edge
        press(16'h1111, 8);
        for (int i = 1; i <= 6; i++) cycle(1'b0, 16'h2222, (i == 6) ? 2'd3 : 2'd0, 1'b0);
        check("t5_ready_kept", {31'h0, InputReady}, 32'h1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0, 2'd0, 1'b0);
        cycle(1'b1, 16'h0, 2'd3, 1'b0);
        check("t5_new_word", IData, 32'h00002222);

        // 6: reset while held and ready, key still held afterwards
        for (int i = 0; i < 8; i++) cycle(1'b0, 16'h00F0, 2'd0, 1'b0);
        cycle(1'b0, 16'h00F0, 2'd0, 1'b1);
        check("t6_rst_ready", {31'h0, InputReady}, 32'h0);
        check("t6_rst_idata", IData, 32'h0);
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b0, 16'h0F0F, 2'd0, 1'b0);
            if (i == 5) check("t6_not_yet", {31'h0, InputReady}, 32'h0);
            if (i == 6) check("t6_ready", {31'h0, InputReady}, 32'h1);
        end
        cycle(1'b0, 16'h0F0F, 2'd3, 1'b0);
        check("t6_data", IData, 32'h00000F0F);

        // Random key runs, switch words, reads and occasional resets
        k = 1'b1;
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                k = ~k;
                run_left = $urandom_range(1, 10);
            end
            run_left--;
            cycle(k, 16'($urandom), ($urandom_range(0, 3) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                  ($urandom_range(0, 299) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
